// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO: enable-decoded register bank, head/tail pointers,
// occupancy count, 7-state control FSM. Optional threshold flags under FIFO_ALMOST_FLAGS_EN.
module param_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err,
  output logic [ADDR_W:0]       data_count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  typedef enum logic [2:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERROR,
    READ,
    RD_ERROR,
    RDWR
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_t                state;
  state_t                state_next;
  logic [ADDR_W-1:0]     head;
  logic [ADDR_W-1:0]     tail;
  logic [ADDR_W:0]       count;
  logic                  side_rej;
  logic                  side_rej_next;
  logic                  do_wr;
  logic                  do_rd;
  logic [DEPTH-1:0]      word_we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign data_count = count;

  // Request decode. side_rej marks a combined request where one half was refused,
  // so a WRITE/READ state can also report the error of the other half.
  always_comb begin
    state_next    = NO_OP;
    side_rej_next = 1'b0;
    do_wr         = 1'b0;
    do_rd         = 1'b0;
    case ({wr_en, rd_en})
      2'b10: begin
        if (full) begin
          state_next = WR_ERROR;
        end else begin
          state_next = WRITE;
          do_wr      = 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          state_next = RD_ERROR;
        end else begin
          state_next = READ;
          do_rd      = 1'b1;
        end
      end
      2'b11: begin
        if (empty) begin
          state_next    = WRITE;
          side_rej_next = 1'b1;
          do_wr         = 1'b1;
        end else if (full) begin
          state_next    = READ;
          side_rej_next = 1'b1;
          do_rd         = 1'b1;
        end else begin
          state_next = RDWR;
          do_wr      = 1'b1;
          do_rd      = 1'b1;
        end
      end
      default: state_next = NO_OP;
    endcase
  end

  always_comb begin
    word_we = '0;
    if (do_wr && !reset) begin
      word_we[tail] = 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (word_we[i]) begin
        mem[i] <= d_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      side_rej <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      d_out    <= '0;
    end else begin
      state    <= state_next;
      side_rej <= side_rej_next;
      if (do_wr) begin
        tail <= tail + 1'b1;
      end
      if (do_rd) begin
        head  <= head + 1'b1;
        d_out <= mem[head];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wr_ack = (state == WRITE) || (state == RDWR);
  assign rd_ack = (state == READ)  || (state == RDWR);
  assign wr_err = (state == WR_ERROR) || ((state == READ)  && side_rej);
  assign rd_err = (state == RD_ERROR) || ((state == WRITE) && side_rej);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count >= (ADDR_W+1)'(DEPTH - 1));
  assign almost_empty = (count <= (ADDR_W+1)'(1));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
